four_to_one_mux: RTL and testbench



---
 rtl/four_to_one_mux.sv | 48 ++++
 tb/tb_four_to_one_mux.sv | 122 ++++++++++++
 2 files changed

// File: rtl/four_to_one_mux.sv
`default_nettype none
// ============================================================================
// Module      : four_to_one_mux
// Description : Registered 4-to-1 multiplexer with load enable and a valid
//               flag marking the first capture since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module four_to_one_mux #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] z,
    output logic             z_valid
);

    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_z;
    logic             r_z_valid;

    // Nested ternaries keep the decode full with no default arm, so an X on
    // either select bit propagates into z in simulation instead of being masked.
    always_comb begin
        w_sel = s1 ? (s0 ? d : c) : (s0 ? b : a);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_z       <= '0;
            r_z_valid <= 1'b0;
        end else if (en) begin
            r_z       <= w_sel;
            r_z_valid <= 1'b1;
        end
    end

    assign z       = r_z;
    assign z_valid = r_z_valid;

endmodule
`default_nettype wire

// File: tb/tb_four_to_one_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_to_one_mux
// Description : Directed scoreboard bench for 1-bit and 8-bit mux instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_to_one_mux;

    logic       clk = 1'b0;
    logic       rst, en, s0, s1;
    logic       a1, b1, c1, d1, z1, zv1;
    logic [7:0] a8, b8, c8, d8, z8;
    logic       zv8;

    always #5 clk = ~clk;

    four_to_one_mux #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1), .c(c1), .d(d1),
        .s0(s0), .s1(s1), .z(z1), .z_valid(zv1)
    );

    four_to_one_mux #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .a(a8), .b(b8), .c(c8), .d(d8),
        .s0(s0), .s1(s1), .z(z8), .z_valid(zv8)
    );

    typedef struct packed {
        logic       z1;
        logic [7:0] z8;
        logic       v;
    } exp_t;

    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    logic       m_z1 = 1'b0;
    logic [7:0] m_z8 = 8'h00;
    logic       m_v  = 1'b0;

    // One clock of stimulus: data packed {d,c,b,a}; expectation pushed at
    // drive time, popped and compared #1 after the capturing edge.
    task automatic step(input logic r, input logic e, input logic [1:0] s,
                        input logic [3:0] v1, input logic [31:0] v8,
                        input string tag);
        logic [7:0] lanes [4];
        exp_t       ex;
        rst = r; en = e; s1 = s[1]; s0 = s[0];
        a1 = v1[0]; b1 = v1[1]; c1 = v1[2]; d1 = v1[3];
        a8 = v8[7:0]; b8 = v8[15:8]; c8 = v8[23:16]; d8 = v8[31:24];
        lanes[0] = a8; lanes[1] = b8; lanes[2] = c8; lanes[3] = d8;
        if (r) begin
            m_z1 = 1'b0; m_z8 = 8'h00; m_v = 1'b0;
        end else if (e) begin
            m_z1 = v1[s]; m_z8 = lanes[s]; m_v = 1'b1;
        end
        sb_q.push_back('{z1: m_z1, z8: m_z8, v: m_v});
        @(posedge clk);
        #1;
        ex = sb_q.pop_front();
        checks++;
        assert (z1 === ex.z1) else begin
            errors++; $error("FAIL %s z1 observed=%b expected=%b", tag, z1, ex.z1);
        end
        checks++;
        assert (z8 === ex.z8) else begin
            errors++; $error("FAIL %s z8 observed=%h expected=%h", tag, z8, ex.z8);
        end
        checks++;
        assert (zv1 === ex.v) else begin
            errors++; $error("FAIL %s z_valid1 observed=%b expected=%b", tag, zv1, ex.v);
        end
        checks++;
        assert (zv8 === ex.v) else begin
            errors++; $error("FAIL %s z_valid8 observed=%b expected=%b", tag, zv8, ex.v);
        end
    endtask

    localparam logic [31:0] c_wide = 32'h44332211;

    initial begin
        // reset with all-ones data and enable asserted
        step(1, 1, 2'b11, 4'hF, 32'hFFFFFFFF, "reset0");
        step(1, 1, 2'b00, 4'hF, 32'hFFFFFFFF, "reset1");
        step(0, 1, 2'b00, 4'h0, 32'h00000000, "release");

        // walking select, only the selected input driven high
        step(0, 1, 2'b00, 4'b0001, 32'h000000A5, "walk_a");
        step(0, 1, 2'b01, 4'b0010, 32'h00005A00, "walk_b");
        step(0, 1, 2'b10, 4'b0100, 32'h00C30000, "walk_c");
        step(0, 1, 2'b11, 4'b1000, 32'h3C000000, "walk_d");
        step(0, 1, 2'b00, 4'b0000, 32'h00000000, "walk_zero");

        // isolation: c held at 0 while the others toggle
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 2'b10, (i % 2 == 0) ? 4'b1011 : 4'b0000,
                 (i % 2 == 0) ? 32'hFF00FFFF : 32'h00000000, "isolate");
        end

        // enable hold
        step(0, 1, 2'b01, 4'b0010, 32'h00007700, "hold_load");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2'b00, 4'b0000, 32'h00000000, "hold");
        end
        step(0, 1, 2'b00, 4'b0000, 32'h00000000, "hold_release");

        // wide sweep
        step(0, 1, 2'b00, 4'b0001, c_wide, "wide_00");
        step(0, 1, 2'b01, 4'b0010, c_wide, "wide_01");
        step(0, 1, 2'b10, 4'b0100, c_wide, "wide_10");
        step(0, 1, 2'b11, 4'b1000, c_wide, "wide_11");

        // mid-operation reset, then recapture
        step(1, 1, 2'b11, 4'b1000, c_wide, "mid_reset");
        step(0, 1, 2'b10, 4'b0100, c_wide, "post_reset");
        step(0, 0, 2'b01, 4'b0000, c_wide, "post_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
